bus_reader: RTL and testbench

- Sysbus initiator that reads a block of consecutive words from a memory responder and reports each word plus a running checksum.
- Drives the same sequence the CPU sequencer drives: address on sysbus with load_MAR asserted, then MDR_bus asserted while it samples sysbus.
- Used for memory dump and self-test of the program store, and sits beside the CPU on the shared sysbus.
- The CPU must hold its sysbus drivers off while busy=1.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/bus_reader.sv | 128 ++++++++++++
 tb/tb_bus_reader.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the sysbus-side blocks of the CPU: word/opcode
// geometry and the block-reader state encoding.
package cpu_pkg;

    localparam int WORD_W_DFLT = 8;
    localparam int OP_W_DFLT   = 3;

    // The operand (address) field is whatever the opcode leaves of a word.
    function automatic int addr_width(input int word_w, input int op_w);
        return word_w - op_w;
    endfunction

    localparam int AW_DFLT = addr_width(WORD_W_DFLT, OP_W_DFLT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        FIN  = 2'd3
    } rd_state_t;

endpackage

// File: rtl/bus_reader.sv
// Sysbus initiator: reads a block of consecutive words through the responder's
// MAR/MDR handshake, reporting each word and a running mod-2^WORD_W checksum.
module bus_reader
    import cpu_pkg::*;
#(
    parameter  int WORD_W = WORD_W_DFLT,
    parameter  int OP_W   = OP_W_DFLT,
    localparam int AW     = addr_width(WORD_W, OP_W)
) (
    input  logic              clock,
    input  logic              n_reset,
    input  logic              start,
    input  logic [AW-1:0]     base_addr,
    input  logic [AW:0]       count,
    inout  wire  [WORD_W-1:0] sysbus,
    output logic              load_MAR,
    output logic              MDR_bus,
    output logic              CS,
    output logic              R_NW,
    output logic              busy,
    output logic              data_valid,
    output logic [WORD_W-1:0] data_out,
    output logic [AW-1:0]     rd_addr,
    output logic [WORD_W-1:0] checksum,
    output logic              done
);

    // Checksum deliberately wraps: only the low WORD_W bits are kept.
    function automatic logic [WORD_W-1:0] csum_add(input logic [WORD_W-1:0] a,
                                                   input logic [WORD_W-1:0] b);
        return a + b;
    endfunction

    rd_state_t         r_state;
    rd_state_t         w_next;
    logic [AW-1:0]     r_addr;
    logic [AW:0]       r_remaining;
    logic [WORD_W-1:0] r_data;
    logic [AW-1:0]     r_rd_addr;
    logic [WORD_W-1:0] r_checksum;
    logic              r_data_valid;
    logic              w_load;
    logic              w_mdr;
    logic              w_busy;
    logic              w_done;
    logic              w_accept;

    assign w_accept = (r_state == IDLE) && start;

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_mdr  = 1'b0;
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = (count == '0) ? FIN : ADDR;
                end
            end
            ADDR: begin
                w_load = 1'b1;
                w_busy = 1'b1;
                w_next = DATA;
            end
            DATA: begin
                w_mdr  = 1'b1;
                w_busy = 1'b1;
                // remaining still holds the pre-decrement value here.
                w_next = (r_remaining == (AW+1)'(1)) ? FIN : ADDR;
            end
            FIN: begin
                w_done = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            r_addr       <= '0;
            r_remaining  <= '0;
            r_data       <= '0;
            r_rd_addr    <= '0;
            r_checksum   <= '0;
            r_data_valid <= 1'b0;
        end else begin
            r_data_valid <= (r_state == DATA);
            if (w_accept) begin
                r_addr      <= base_addr;
                r_remaining <= count;
                r_checksum  <= '0;
            end
            if (r_state == DATA) begin
                r_data      <= sysbus;
                r_rd_addr   <= r_addr;
                r_checksum  <= csum_add(r_checksum, sysbus);
                r_addr      <= r_addr + AW'(1);
                r_remaining <= r_remaining - (AW+1)'(1);
            end
        end
    end

    // Only ADDR drives the bus, so this can never fight the responder's MDR.
    assign sysbus = w_load ? {{OP_W{1'b0}}, r_addr} : {WORD_W{1'bz}};

    assign load_MAR   = w_load;
    assign MDR_bus    = w_mdr;
    assign CS         = w_busy;
    assign busy       = w_busy;
    assign done       = w_done;
    assign R_NW       = 1'b1;
    assign data_valid = r_data_valid;
    assign data_out   = r_data;
    assign rd_addr    = r_rd_addr;
    assign checksum   = r_checksum;

endmodule

// File: tb/tb_bus_reader.sv
// Self-checking bench for bus_reader: behavioural memory responder, a
// transaction-level timing model, directed scenarios and randomized blocks.
module tb_bus_reader;

    logic       clock = 1'b0;
    logic       n_reset = 1'b0;
    logic       start = 1'b0;
    logic [4:0] base_addr = '0;
    logic [5:0] count = '0;
    wire  [7:0] sysbus;
    logic       load_MAR, MDR_bus, CS, R_NW, busy, data_valid, done;
    logic [7:0] data_out, checksum;
    logic [4:0] rd_addr;

    bus_reader #(.WORD_W(8), .OP_W(3)) dut (
        .clock(clock), .n_reset(n_reset), .start(start),
        .base_addr(base_addr), .count(count), .sysbus(sysbus),
        .load_MAR(load_MAR), .MDR_bus(MDR_bus), .CS(CS), .R_NW(R_NW),
        .busy(busy), .data_valid(data_valid), .data_out(data_out),
        .rd_addr(rd_addr), .checksum(checksum), .done(done)
    );

    always #5 clock = ~clock;

    // Behavioural memory responder
    logic [7:0] mem [0:31];
    logic [4:0] mar = '0;
    always @(posedge clock) if (load_MAR) mar <= sysbus[4:0];
    assign sysbus = MDR_bus ? mem[mar] : 8'bz;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
        end
    endtask

    // Transaction model: a block of N words accepted at edge s occupies
    // relative cycles 0..2N-1 (even = address phase, odd = data phase),
    // word k appears in the outputs at relative cycle 2k+2, done at 2N.
    bit         act = 0;
    int         edge_n = 0;
    int         s = 0;
    int         nw = 0;
    logic [4:0] wadr [0:32];
    logic [7:0] wdat [0:32];
    logic [7:0] csum [0:32];
    logic [7:0] e_data = '0;
    logic [7:0] e_cs = '0;
    logic [4:0] e_rd = '0;

    initial forever begin
        @(posedge clock or negedge n_reset);
        if (!n_reset) begin
            act = 0; edge_n = 0; e_data = '0; e_cs = '0; e_rd = '0;
        end else begin
            bit idle_pre;
            int r;
            int sum;
            idle_pre = !act || (edge_n - s > 2 * nw);
            edge_n++;
            if (idle_pre) begin
                act = 0;
                if (start) begin
                    act = 1; s = edge_n; nw = int'(count); e_cs = '0;
                    sum = 0;
                    for (int k = 0; k < nw; k++) begin
                        wadr[k] = 5'((int'(base_addr) + k) % 32);
                        wdat[k] = mem[wadr[k]];
                        sum = (sum + int'(wdat[k])) % 256;
                        csum[k] = 8'(sum);
                    end
                end
            end else begin
                r = edge_n - s;
                if (r >= 2 && r <= 2 * nw && r % 2 == 0) begin
                    e_data = wdat[r/2 - 1];
                    e_rd   = wadr[r/2 - 1];
                    e_cs   = csum[r/2 - 1];
                end
            end
        end
    end

    // Per-cycle comparison against the model
    initial forever begin
        @(negedge clock);
        if (n_reset) begin
            int r;
            bit ab, ld, md, dn, dv;
            r  = edge_n - s;
            ab = act && r < 2 * nw;
            ld = ab && (r % 2 == 0);
            md = ab && (r % 2 == 1);
            dn = act && r == 2 * nw;
            dv = act && r >= 2 && r <= 2 * nw && (r % 2 == 0);
            chk("busy", busy, ab);
            chk("load_MAR", load_MAR, ld);
            chk("MDR_bus", MDR_bus, md);
            chk("CS", CS, ab);
            chk("done", done, dn);
            chk("data_valid", data_valid, dv);
            chk("R_NW", R_NW, 1);
            chk("data_out", data_out, e_data);
            chk("rd_addr", rd_addr, e_rd);
            chk("checksum", checksum, e_cs);
            if (ld) chk("sysbus_addr", sysbus, {3'b000, wadr[r/2]});
            if (md) chk("sysbus_data", sysbus, wdat[(r-1)/2]);
        end
    end

    task automatic pulse_start(input logic [4:0] b, input logic [5:0] c);
        @(negedge clock);
        start = 1'b1; base_addr = b; count = c;
        @(negedge clock);
        start = 1'b0; base_addr = 5'($urandom); count = 6'($urandom);
    endtask

    task automatic run_done(input int budget, output int nb, output int ndv, output int ndone);
        nb = 0; ndv = 0; ndone = 0;
        for (int i = 0; i < budget; i++) begin
            if (busy) nb++;
            if (data_valid) ndv++;
            if (done) begin
                ndone++;
                break;
            end
            @(negedge clock);
        end
        chk("done_seen", ndone, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb, ndv, nd, extra;
        for (int a = 0; a < 32; a++) mem[a] = '0;

        // Reset state
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_R_NW", R_NW, 1);
        chk("rst_data_out", data_out, 0);
        chk("rst_load_MAR", load_MAR, 0);
        @(negedge clock); n_reset = 1'b1;
        repeat (2) @(negedge clock);

        // Single word
        mem[2] = 8'h45;
        pulse_start(5'd2, 6'd1);
        chk("t1_load_MAR_c1", load_MAR, 1);
        @(negedge clock);
        chk("t1_MDR_bus_c2", MDR_bus, 1);
        @(negedge clock);
        chk("t1_done_c3", done, 1);
        chk("t1_data_out", data_out, 8'h45);
        chk("t1_rd_addr", rd_addr, 2);
        chk("t1_checksum", checksum, 8'h45);

        // Zero count
        pulse_start(5'd7, 6'd0);
        chk("t4_done", done, 1);
        chk("t4_load_MAR", load_MAR, 0);
        chk("t4_busy", busy, 0);
        chk("t4_checksum", checksum, 0);
        @(negedge clock);
        chk("t4_done_once", done, 0);

        // Block read
        for (int a = 0; a < 32; a++) mem[a] = 8'(a + 1);
        pulse_start(5'd0, 6'd4);
        run_done(40, nb, ndv, nd);
        chk("t2_busy_cycles", nb, 8);
        chk("t2_valid_pulses", ndv, 4);
        chk("t2_checksum", checksum, 8'd10);
        chk("t2_last_word", data_out, 8'd4);

        // Wrap
        for (int a = 0; a < 32; a++) mem[a] = 8'h80;
        pulse_start(5'd30, 6'd4);
        run_done(40, nb, ndv, nd);
        chk("t3_rd_addr", rd_addr, 1);
        chk("t3_checksum", checksum, 8'h00);
        chk("t3_data_out", data_out, 8'h80);

        // Reset mid-transfer (second data phase)
        for (int a = 0; a < 32; a++) mem[a] = 8'(a + 1);
        pulse_start(5'd0, 6'd4);
        repeat (3) @(posedge clock);
        #2 n_reset = 1'b0;
        #1;
        chk("t5_busy", busy, 0);
        chk("t5_MDR_bus", MDR_bus, 0);
        chk("t5_CS", CS, 0);
        chk("t5_done", done, 0);
        chk("t5_data_valid", data_valid, 0);
        chk("t5_data_out", data_out, 0);
        chk("t5_checksum", checksum, 0);
        chk("t5_R_NW", R_NW, 1);
        @(negedge clock); n_reset = 1'b1;
        repeat (4) @(negedge clock);
        mem[5] = 8'hA5;
        pulse_start(5'd5, 6'd1);
        run_done(20, nb, ndv, nd);
        chk("t5_after_data", data_out, 8'hA5);
        chk("t5_after_addr", rd_addr, 5);

        // Start while busy
        pulse_start(5'd10, 6'd3);
        @(negedge clock);
        pulse_start(5'd20, 6'd2);
        run_done(40, nb, ndv, nd);
        chk("t6_rd_addr", rd_addr, 12);
        extra = 0;
        repeat (6) begin
            @(negedge clock);
            if (done) extra++;
        end
        chk("t6_extra_done", extra, 0);

        // Randomized blocks
        for (int it = 0; it < 30; it++) begin
            int sel;
            logic [5:0] c;
            for (int a = 0; a < 32; a++) mem[a] = 8'($urandom);
            sel = $urandom_range(0, 9);
            c = (sel == 0) ? 6'd0 : (sel == 1) ? 6'd32 : 6'($urandom_range(1, 8));
            pulse_start(5'($urandom), c);
            if (c >= 3 && $urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(0, 3)) @(negedge clock);
                start = 1'b1; count = 6'($urandom_range(1, 8));
                @(negedge clock);
                start = 1'b0;
            end
            run_done(200, nb, ndv, nd);
            if ($urandom_range(0, 1) == 1) begin
                start = 1'b1; count = 6'($urandom_range(1, 8));
                @(negedge clock);
                start = 1'b0;
            end
            repeat ($urandom_range(0, 3)) @(negedge clock);
        end

        repeat (3) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
